// File: rtl/tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_pkg
// Shared types and constants for the TDM demultiplexer.
//   state_t      : receiver lock state (HUNT = searching for sync, RECV = locked)
//   PARITY_SLOTS : extra slots per frame (1 when TDM_DEMUX_PARITY_EN is defined)
//   slot_width() : bits needed to index every slot of a frame
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds a trailing parity slot).
// -----------------------------------------------------------------------------
package tdm_demux_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int PARITY_SLOTS = 1;
`else
    localparam int PARITY_SLOTS = 0;
`endif

    // A one-bit counter is the narrowest useful width, even for two slots.
    function automatic int slot_width(input int slots);
        return (slots > 2) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
// Slot position within the current frame.
//   clk, srst-style synchronous reset on rst (active high)
//   inc   : advance one slot, wrapping from SLOTS-1 to 0
//   load1 : force slot to 1 (a sync beat has just been stored as slot 0);
//           takes priority over inc
//   slot  : current slot index
//   last  : high when slot is the final slot of the frame
// -----------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int SW    = slot_width(SLOTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          load1,
    output logic [SW-1:0] slot,
    output logic          last
);

    logic [SW-1:0] slot_reg;
    logic [SW-1:0] slot_next;

    always_comb begin
        slot_next = slot_reg;
        if (load1) begin
            slot_next = SW'(1);
        end else if (inc) begin
            slot_next = (slot_reg == SW'(SLOTS - 1)) ? '0 : slot_reg + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign slot = slot_reg;
    assign last = (slot_reg == SW'(SLOTS - 1));

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Receive-side time-division demultiplexer. Serial lane words arrive in fixed
// slot order; a frame_sync beat marks slot 0. Complete frames are presented in
// parallel on registered outputs with a one-cycle dout_valid strobe.
// Ports:
//   clk, rst (synchronous, active high)
//   din        : lane word for the current slot (sampled when din_valid)
//   din_valid  : beat qualifier; non-beat cycles are ignored
//   frame_sync : marks the slot-0 beat (qualified by din_valid)
//   dout       : lane k at [k*LANE_W +: LANE_W], updates only with dout_valid
//   dout_valid : one-cycle pulse, new frame on dout
//   sync_err   : one-cycle pulse, sync seen mid-frame (partial frame dropped)
//   locked     : high while receiving (RECV)
//   parity_err : (TDM_DEMUX_PARITY_EN only) one-cycle pulse, frame dropped
// Optional feature macro: TDM_DEMUX_PARITY_EN -- each frame carries one extra
// trailing slot whose bit 0 is the even parity over all lane bits.
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANE_W-1:0]           din,
    input  logic                        din_valid,
    input  logic                        frame_sync,
    output logic [NUM_LANES*LANE_W-1:0] dout,
    output logic                        dout_valid,
    output logic                        sync_err,
    output logic                        locked
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic                        parity_err
`endif
);

    localparam int SLOTS = NUM_LANES + PARITY_SLOTS;
    localparam int SW    = slot_width(SLOTS);
    localparam int DW    = NUM_LANES * LANE_W;

    state_t          state_reg;
    state_t          state_next;

    logic [SW-1:0]   slot;
    logic            slot_last;
    logic            cnt_inc;
    logic            cnt_load1;
    logic            capture;
    logic            frame_done;
    logic            frame_accept;
    logic            sync_err_next;
    logic [SW-1:0]   wr_idx;

    logic [DW-1:0]        shadow_reg;
    logic [DW-1:0]        frame_word;
    logic [NUM_LANES-1:0] lane_hit;

    logic [DW-1:0]   dout_reg;
    logic            dout_valid_reg;
    logic            sync_err_reg;

    tdm_slot_counter #(
        .SLOTS (SLOTS),
        .SW    (SW)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .slot  (slot),
        .last  (slot_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_inc       = 1'b0;
        cnt_load1     = 1'b0;
        capture       = 1'b0;
        frame_done    = 1'b0;
        sync_err_next = 1'b0;
        case (state_reg)
            HUNT: begin
                if (din_valid && frame_sync) begin
                    state_next = RECV;
                    cnt_load1  = 1'b1;
                    capture    = 1'b1;
                end
            end
            RECV: begin
                if (din_valid) begin
                    capture = 1'b1;
                    if (frame_sync && (slot != '0)) begin
                        // Restart the frame on this beat; older lanes in the
                        // shadow are stale but will be overwritten before use.
                        sync_err_next = 1'b1;
                        cnt_load1     = 1'b1;
                    end else begin
                        cnt_inc    = 1'b1;
                        frame_done = slot_last;
                    end
                end
            end
            default: state_next = HUNT;
        endcase
    end

    // A (re)sync beat is always slot 0 regardless of the counter value.
    assign wr_idx = cnt_load1 ? '0 : slot;

    // Per-lane shadow storage. frame_word is the shadow with the current beat
    // merged in, so the last lane can go straight to dout on its own beat.
    // The parity slot index is >= NUM_LANES and so never hits a lane.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_hit[gi] = capture && (wr_idx == SW'(gi));
            assign frame_word[gi*LANE_W +: LANE_W] =
                lane_hit[gi] ? din : shadow_reg[gi*LANE_W +: LANE_W];

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi*LANE_W +: LANE_W] <= '0;
                end else if (lane_hit[gi]) begin
                    shadow_reg[gi*LANE_W +: LANE_W] <= din;
                end
            end
        end
    endgenerate

`ifdef TDM_DEMUX_PARITY_EN
    logic parity_ok;
    logic parity_err_reg;

    // Even parity: the parity bit equals the XOR of all lane bits.
    assign parity_ok    = ((^frame_word) == din[0]);
    assign frame_accept = frame_done && parity_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_reg <= 1'b0;
        end else begin
            parity_err_reg <= frame_done && !parity_ok;
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign frame_accept = frame_done;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            dout_valid_reg <= frame_accept;
            sync_err_reg   <= sync_err_next;
            if (frame_accept) begin
                dout_reg <= frame_word;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign sync_err   = sync_err_reg;
    assign locked     = (state_reg == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
`timescale 1ns/1ps
module tb_tdm_demux;
    import tdm_demux_pkg::*;

    localparam int NL    = 4;
    localparam int LW    = 1;
    localparam int SLOTS = NL + PARITY_SLOTS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [LW-1:0]     din = '0;
    logic              din_valid = 1'b0;
    logic              frame_sync = 1'b0;
    logic [NL*LW-1:0]  dout;
    logic              dout_valid;
    logic              sync_err;
    logic              locked;
`ifdef TDM_DEMUX_PARITY_EN
    logic              parity_err;
`endif

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_serr   = 0;
    int n_perr   = 0;

    always #5 clk = ~clk;

    tdm_demux #(
        .NUM_LANES (NL),
        .LANE_W    (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_err   (sync_err),
        .locked     (locked)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    // One clock: apply inputs, take the edge, sample 1ns later, tally pulses.
    task automatic drive(input logic v, input logic s, input logic [LW-1:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        if (dout_valid) n_valid++;
        if (sync_err)   n_serr++;
`ifdef TDM_DEMUX_PARITY_EN
        if (parity_err) n_perr++;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n_valid = 0;
        n_serr  = 0;
        n_perr  = 0;
    endtask

    // Sends one frame, sync on lane 0, 'gap' idle cycles before every beat,
    // plus a correct parity beat when parity is enabled.
    task automatic send_frame(input logic [NL*LW-1:0] lanes, input int gap);
        for (int i = 0; i < NL; i++) begin
            idle(gap);
            drive(1'b1, (i == 0), lanes[i*LW +: LW]);
        end
`ifdef TDM_DEMUX_PARITY_EN
        idle(gap);
        drive(1'b1, 1'b0, LW'(^lanes));
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h want=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b want=0", dout_valid); end
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err got=%b want=0", sync_err); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", locked); end
        rst = 1'b0;
        n_valid = 0; n_serr = 0; n_perr = 0;
    endtask

    task automatic test_basic();
        do_reset();
        send_frame(4'b1101, 0);
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", dout_valid); end
        checks++; if (dout !== 4'b1101) begin failures++; $display("FAIL basic_dout got=%b want=1101", dout); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL basic_locked got=%b want=1", locked); end
        idle(3);
        checks++; if (n_valid != 1) begin failures++; $display("FAIL basic_valid_count got=%0d want=1", n_valid); end
        checks++; if (dout !== 4'b1101) begin failures++; $display("FAIL basic_dout_hold got=%b want=1101", dout); end
    endtask

    task automatic test_no_sync();
        do_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, LW'($urandom_range(0, 1)));
        checks++; if (n_valid != 0) begin failures++; $display("FAIL nosync_valid_count got=%0d want=0", n_valid); end
        checks++; if (dout !== '0) begin failures++; $display("FAIL nosync_dout got=%b want=0", dout); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL nosync_locked got=%b want=0", locked); end
    endtask

    task automatic test_gaps();
        do_reset();
        send_frame(4'b1101, 2);
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL gaps_valid got=%b want=1", dout_valid); end
        checks++; if (dout !== 4'b1101) begin failures++; $display("FAIL gaps_dout got=%b want=1101", dout); end
        checks++; if (n_valid != 1) begin failures++; $display("FAIL gaps_valid_count got=%0d want=1", n_valid); end
    endtask

    task automatic test_sync_err();
        do_reset();
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL syncerr_pulse got=%b want=1", sync_err); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL syncerr_width got=%b want=0", sync_err); end
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        drive(1'b1, 1'b0, 1'b1);
`endif
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL syncerr_valid got=%b want=1", dout_valid); end
        checks++; if (dout !== 4'b0100) begin failures++; $display("FAIL syncerr_dout got=%b want=0100", dout); end
        checks++; if (n_serr != 1 || n_valid != 1) begin failures++; $display("FAIL syncerr_counts got serr=%0d valid=%0d want 1/1", n_serr, n_valid); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midrst_locked got=%b want=0", locked); end
        idle(2);
        checks++; if (n_valid != 0) begin failures++; $display("FAIL midrst_no_valid got=%0d want=0", n_valid); end
        send_frame(4'b0110, 0);
        checks++; if (dout_valid !== 1'b1 || dout !== 4'b0110) begin failures++; $display("FAIL midrst_dout got=%b/%b want=1/0110", dout_valid, dout); end
    endtask

    task automatic test_back_to_back();
        logic [NL*LW-1:0] w;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            w = (NL*LW)'($urandom);
            send_frame(w, 0);
            checks++; if (dout_valid !== 1'b1 || dout !== w) begin failures++; $display("FAIL b2b_frame%0d got=%b/%h want=1/%h", f, dout_valid, dout, w); end
        end
        checks++; if (n_valid != 3) begin failures++; $display("FAIL b2b_count got=%0d want=3", n_valid); end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_frame(4'b1101, 0);
        checks++; if (dout_valid !== 1'b1 || parity_err !== 1'b0) begin failures++; $display("FAIL parity_good got=%b/%b want=1/0", dout_valid, parity_err); end
        // Same lanes, wrong parity bit.
        drive(1'b1, 1'b1, 1'b1); drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (parity_err !== 1'b1 || dout_valid !== 1'b0) begin failures++; $display("FAIL parity_bad got=%b/%b want=1/0", parity_err, dout_valid); end
        // Different lanes, wrong parity: dout must keep the earlier frame.
        drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        checks++; if (parity_err !== 1'b1 || dout !== 4'b1101) begin failures++; $display("FAIL parity_hold got=%b/%b want=1/1101", parity_err, dout); end
        idle(1);
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL parity_width got=%b want=0", parity_err); end
    endtask
`endif

    // Random beats, gaps and syncs against a queue-based model of the framing
    // rules: a frame is the list of words collected since the last slot 0.
    task automatic test_random();
        logic [LW-1:0]    q[$];
        logic [NL*LW-1:0] w;
        logic [NL*LW-1:0] exp_dout;
        bit m_locked, v, s, exp_valid, exp_serr, exp_perr, ok;
        logic [LW-1:0] d;
        do_reset();
        m_locked = 0;
        exp_dout = '0;
        q.delete();
        for (int c = 0; c < 800; c++) begin
            v = ($urandom_range(0, 9) < 7);
            s = v && ($urandom_range(0, 99) < 8);
            d = LW'($urandom);
            exp_valid = 0; exp_serr = 0; exp_perr = 0;
            if (v) begin
                if (!m_locked) begin
                    if (s) begin m_locked = 1; q.delete(); q.push_back(d); end
                end else if (s && q.size() != 0) begin
                    exp_serr = 1;
                    q.delete();
                    q.push_back(d);
                end else begin
                    q.push_back(d);
                    if (q.size() == SLOTS) begin
                        for (int k = 0; k < NL; k++) w[k*LW +: LW] = q[k];
                        ok = 1;
                        if (SLOTS > NL) ok = ((^w) == q[SLOTS-1][0]);
                        if (ok) begin exp_valid = 1; exp_dout = w; end
                        else exp_perr = 1;
                        q.delete();
                    end
                end
            end
            drive(v, s, d);
            checks++; if (dout_valid !== exp_valid) begin failures++; $display("FAIL rand_valid c=%0d got=%b want=%b", c, dout_valid, exp_valid); end
            checks++; if (dout !== exp_dout) begin failures++; $display("FAIL rand_dout c=%0d got=%h want=%h", c, dout, exp_dout); end
            checks++; if (sync_err !== exp_serr) begin failures++; $display("FAIL rand_sync_err c=%0d got=%b want=%b", c, sync_err, exp_serr); end
            checks++; if (locked !== m_locked) begin failures++; $display("FAIL rand_locked c=%0d got=%b want=%b", c, locked, m_locked); end
`ifdef TDM_DEMUX_PARITY_EN
            checks++; if (parity_err !== exp_perr) begin failures++; $display("FAIL rand_parity_err c=%0d got=%b want=%b", c, parity_err, exp_perr); end
`else
            checks++; if (exp_perr) begin failures++; $display("FAIL rand_model_perr c=%0d got=1 want=0", c); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_sync();
        test_gaps();
        test_sync_err();
        test_reset_midframe();
        test_back_to_back();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
